// File: rtl/mux_n_1_stream_rr.sv
// mux_n_1_stream_rr
//   N-channel, W-bit valid/ready stream multiplexer with a registered output
//   stage. The winning channel is chosen either by round-robin arbitration
//   among the valid channels or by an external channel select (sel_en=1).
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   in_data      packed channel data, channel i at [i*W +: W]
//   in_valid     per-channel valid
//   in_ready     per-channel accept (combinational: load & grant)
//   sel_en, sel  external select mode enable and channel index
//   out_data     registered data of the last accepted word
//   out_ch       channel index the registered word came from
//   out_valid    out_data/out_ch hold a word for the consumer
//   out_ready    consumer accepts the registered word this cycle
module mux_n_1_stream_rr #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 4,
    localparam int unsigned CW  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic              sel_en,
    input  logic [CW-1:0]     sel,
    output logic [W-1:0]      out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [W-1:0]    data_q,  data_d;
    logic [CW-1:0]   ch_q,    ch_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   ptr_q,   ptr_d;

    logic [N_CH-1:0] grant_c;
    logic [CW-1:0]   gidx_c;
    logic            load_c;
    logic            xfer_c;

    // Unpack the flat data bus into per-channel words
    logic [W-1:0] ch_data [N_CH];
    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*W +: W];
    end

    // Grant: external select, or first valid channel after the last winner
    always_comb begin
        logic        found;
        int unsigned idx;
        grant_c = '0;
        gidx_c  = '0;
        found   = 1'b0;
        idx     = 0;
        if (sel_en) begin
            // Out-of-range select indices never grant
            if (32'(sel) < N_CH) begin
                if (in_valid[sel]) begin
                    grant_c[sel] = 1'b1;
                    gidx_c       = sel;
                end
            end
        end else begin
            for (int unsigned k = 1; k <= N_CH; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                if (!found && in_valid[CW'(idx)]) begin
                    grant_c[CW'(idx)] = 1'b1;
                    gidx_c            = CW'(idx);
                    found             = 1'b1;
                end
            end
        end
    end

    // The output stage can refill in the same cycle its word is consumed
    assign load_c   = ~valid_q | out_ready;
    assign xfer_c   = load_c & (|grant_c);
    assign in_ready = {N_CH{load_c}} & grant_c;

    // Next-state for the output register and round-robin pointer
    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_c) begin
            if (xfer_c) begin
                data_d  = ch_data[gidx_c];
                ch_d    = gidx_c;
                valid_d = 1'b1;
                ptr_d   = gidx_c;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers; pointer resets to the last channel so channel 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= CW'(N_CH - 1);
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_n_1_stream_rr.sv
// Testbench for mux_n_1_stream_rr: a 4-channel and a 3-channel instance,
// table-driven directed vectors, hand sequences and randomized traffic
// checked against a behavioural model of the arbitration rules.
module tb_mux_n_1_stream_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [15:0] a_data;
    logic [3:0]  a_valid, a_ready;
    logic        a_se, a_ordy, a_ovalid;
    logic [1:0]  a_sel, a_och;
    logic [3:0]  a_odata;

    // 3-channel instance
    logic [11:0] b_data;
    logic [2:0]  b_valid, b_ready;
    logic        b_se, b_ordy, b_ovalid;
    logic [1:0]  b_sel, b_och;
    logic [3:0]  b_odata;

    mux_n_1_stream_rr #(.N_CH(4), .W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .sel_en(a_se), .sel(a_sel),
        .out_data(a_odata), .out_ch(a_och), .out_valid(a_ovalid),
        .out_ready(a_ordy)
    );

    mux_n_1_stream_rr #(.N_CH(3), .W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .sel_en(b_se), .sel(b_sel),
        .out_data(b_odata), .out_ch(b_och), .out_valid(b_ovalid),
        .out_ready(b_ordy)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model state, index 0 = 4-channel, 1 = 3-channel
    int   m_ptr [2];
    bit   m_val [2];
    int   m_data[2];
    int   m_ch  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr[0] = 3; m_ptr[1] = 2;
        for (int d = 0; d < 2; d++) begin
            m_val[d] = 1'b0; m_data[d] = 0; m_ch[d] = 0;
        end
    endtask

    // Which channel wins: -1 for none
    function automatic int mgrant(input int n, input logic [3:0] iv, input logic se,
                                  input logic [1:0] s, input int ptr);
        if (se) begin
            if (int'(s) < n && iv[s]) return int'(s);
            return -1;
        end
        for (int k = 1; k <= n; k++) begin
            if (iv[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    // One clock cycle: check in_ready mid-cycle, advance model, check outputs
    task automatic step();
        int          n, g;
        logic [3:0]  iv, rdy, exp_rdy;
        logic [15:0] dat;
        logic        se, ordy, ld;
        logic [1:0]  s;
        #3;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                n = 4; iv = a_valid; dat = a_data; se = a_se; s = a_sel;
                ordy = a_ordy; rdy = a_ready;
            end else begin
                n = 3; iv = {1'b0, b_valid}; dat = {4'h0, b_data}; se = b_se; s = b_sel;
                ordy = b_ordy; rdy = {1'b0, b_ready};
            end
            g = mgrant(n, iv, se, s, m_ptr[d]);
            ld = !m_val[d] || ordy;
            exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'h0;
            check($sformatf("in_ready[%0d]", d), 32'(rdy), 32'(exp_rdy));
            if (ld) begin
                if (g >= 0) begin
                    m_val[d] = 1'b1; m_ch[d] = g; m_ptr[d] = g;
                    m_data[d] = int'((dat >> (g * 4)) & 16'h000F);
                end else begin
                    m_val[d] = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        check("out_valid[0]", 32'(a_ovalid), 32'(m_val[0]));
        check("out_data[0]",  32'(a_odata),  32'(m_data[0]));
        check("out_ch[0]",    32'(a_och),    32'(m_ch[0]));
        check("out_valid[1]", 32'(b_ovalid), 32'(m_val[1]));
        check("out_data[1]",  32'(b_odata),  32'(m_data[1]));
        check("out_ch[1]",    32'(b_och),    32'(m_ch[1]));
    endtask

    typedef struct {
        logic [3:0] iv;
        logic       se;
        logic [1:0] sel;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] ch;
        logic [3:0] dat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int b_exp_ch[4];
        // Directed 4-channel vectors, data channel0..3 = A,B,C,D
        //        iv     se    sel   ordy  rdy    ov    ch    dat
        // Round-robin, all valid
        tbl.push_back('{4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 4'hA});
        tbl.push_back('{4'hF, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 4'hB});
        tbl.push_back('{4'hF, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 4'hC});
        tbl.push_back('{4'hF, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 4'hD});
        tbl.push_back('{4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 4'hA});
        // Only channels 1 and 3 valid
        tbl.push_back('{4'hA, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 4'hB});
        tbl.push_back('{4'hA, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 4'hD});
        tbl.push_back('{4'hA, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 4'hB});
        tbl.push_back('{4'hA, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 4'hD});
        // Consumer stall for 5 cycles, then back-to-back load
        for (int i = 0; i < 5; i++)
            tbl.push_back('{4'hA, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd3, 4'hD});
        tbl.push_back('{4'hA, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 4'hB});
        // External select channel 2
        tbl.push_back('{4'hF, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 2'd2, 4'hC});
        tbl.push_back('{4'hF, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 2'd2, 4'hC});
        // Channel 2 drops: word held while stalled, then out_valid falls
        tbl.push_back('{4'hB, 1'b1, 2'd2, 1'b0, 4'h0, 1'b1, 2'd2, 4'hC});
        tbl.push_back('{4'hB, 1'b1, 2'd2, 1'b1, 4'h0, 1'b0, 2'd2, 4'hC});
        // Switch back to round-robin in the same cycle, continues after ch2
        tbl.push_back('{4'hF, 1'b0, 2'd2, 1'b1, 4'h8, 1'b1, 2'd3, 4'hD});

        rst_n = 1'b0;
        a_data = 16'hDCBA; a_valid = '0; a_se = 1'b0; a_sel = '0; a_ordy = 1'b0;
        b_data = 12'h321;  b_valid = '0; b_se = 1'b0; b_sel = '0; b_ordy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst out_valid", 32'(a_ovalid), 32'h0);
        check("rst out_data",  32'(a_odata),  32'h0);
        check("rst out_ch",    32'(a_och),    32'h0);
        check("rst b out_valid", 32'(b_ovalid), 32'h0);

        foreach (tbl[i]) begin
            a_valid = tbl[i].iv; a_se = tbl[i].se; a_sel = tbl[i].sel; a_ordy = tbl[i].ordy;
            #2;
            check($sformatf("tbl%0d in_ready", i), 32'(a_ready), 32'(tbl[i].rdy));
            step();
            check($sformatf("tbl%0d out_valid", i), 32'(a_ovalid), 32'(tbl[i].ov));
            check($sformatf("tbl%0d out_ch", i),    32'(a_och),    32'(tbl[i].ch));
            check($sformatf("tbl%0d out_data", i),  32'(a_odata),  32'(tbl[i].dat));
        end
        a_valid = '0; a_se = 1'b0;

        // 3-channel: out-of-range select gives no grant
        b_valid = 3'b111; b_se = 1'b1; b_sel = 2'd3; b_ordy = 1'b1;
        #2 check("b sel3 in_ready", 32'(b_ready), 32'h0);
        step();
        check("b sel3 out_valid", 32'(b_ovalid), 32'h0);
        // 3-channel round-robin wraps 2 -> 0
        b_se = 1'b0;
        b_exp_ch = '{0, 1, 2, 0};
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("b rr%0d out_ch", i), 32'(b_och), 32'(b_exp_ch[i]));
        end

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_data  = 16'($urandom);
            a_valid = 4'($urandom);
            a_se    = ($urandom_range(0, 3) == 0);
            a_sel   = 2'($urandom);
            a_ordy  = ($urandom_range(0, 3) != 0);
            b_data  = 12'($urandom);
            b_valid = 3'($urandom);
            b_se    = ($urandom_range(0, 3) == 0);
            b_sel   = 2'($urandom);
            b_ordy  = ($urandom_range(0, 3) != 0);
            step();
        end

        // Async reset while a word is held under backpressure
        a_data = 16'hDCBA; a_valid = 4'hF; a_se = 1'b0; a_ordy = 1'b1;
        b_valid = '0; b_se = 1'b0; b_ordy = 1'b1;
        step();
        a_ordy = 1'b0;
        step();
        check("pre-rst out_valid", 32'(a_ovalid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(a_ovalid), 32'h0);
        check("async rst out_data",  32'(a_odata),  32'h0);
        check("async rst out_ch",    32'(a_och),    32'h0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        a_ordy = 1'b1;
        step();
        check("post-rst first ch", 32'(a_och), 32'h0);
        step();
        check("post-rst second ch", 32'(a_och), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
